// File: rtl/regfile_dump_reader.sv
// Walks an inclusive register address range through a combinational register-file read port.
// Each word is captured and streamed out with its index over a valid/ready handshake.
module regfile_dump_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cur_reg, last_reg;
  logic [ADDR_W-1:0] out_addr_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_valid_reg, busy_reg, done_reg, err_reg;

  logic accept, reject, handshake, at_last;

  assign accept    = (state_reg == IDLE) && start && (first_addr <= last_addr);
  assign reject    = (state_reg == IDLE) && start && (first_addr > last_addr);
  assign handshake = (state_reg == SEND) && out_valid_reg && out_ready;
  // Compare before incrementing so a range ending at the top address never wraps.
  assign at_last   = (cur_reg == last_reg);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = READ;
      READ: state_next = SEND;
      SEND: if (handshake) state_next = at_last ? DONE : READ;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: the read address is only presented during the capture cycle.
  always_comb begin
    rf_addr = '0;
    if (state_reg == READ) begin
      rf_addr = cur_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_reg       <= '0;
      last_reg      <= '0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= reject;
      if (accept) begin
        cur_reg  <= first_addr;
        last_reg <= last_addr;
        busy_reg <= 1'b1;
      end
      if (state_reg == READ) begin
        out_data_reg  <= rf_data;
        out_addr_reg  <= cur_reg;
        out_valid_reg <= 1'b1;
      end
      if (handshake) begin
        out_valid_reg <= 1'b0;
        if (at_last) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end else begin
          cur_reg <= cur_reg + ADDR_W'(1);
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_addr  = out_addr_reg;
  assign out_data  = out_data_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: a bench-side register file, an expected-word
// queue built from register snapshots, and one compare process checking every cycle.
module tb_regfile_dump_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  first_addr, last_addr;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid, out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        busy, done, err;

  regfile_dump_reader #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .first_addr(first_addr), .last_addr(last_addr),
    .rf_addr(rf_addr), .rf_data(rf_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0] regs [32];
  assign rf_data = regs[rf_addr];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } word_t;

  word_t       exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          t_start  = 0;
  int          done_cnt = 0;
  int          err_cnt  = 0;
  int          accepted = 0;
  int          done_cyc = 0;
  int          word_cyc [32];
  logic [31:0] got_data [32];
  bit          fresh    = 1'b1;
  bit          in_dump  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every word on the output must be the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {59'd0, out_addr}, 64'hFFFF);
        end else begin
          if (fresh) begin
            word_cyc[out_addr] = cyc;
            fresh = 1'b0;
          end
          chk("word_addr", out_addr, exp_q[0].addr);
          chk("word_data", out_data, exp_q[0].data);
          if (out_ready) begin
            got_data[out_addr] = out_data;
            $display("word addr=%0d data=0x%08h cycle=%0d", out_addr, out_data, cyc);
            void'(exp_q.pop_front());
            accepted++;
            fresh = 1'b1;
          end
        end
      end
      if (in_dump && !done) chk("busy_during_dump", busy, 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        in_dump  = 1'b0;
        chk("queue_empty_at_done", exp_q.size(), 0);
        chk("busy_low_at_done", busy, 0);
      end
      if (err) err_cnt++;
    end
  end

  // Drive start after edge N; the DUT samples it at edge N+1. Returns after N+1.
  task automatic raw_start(input logic [4:0] f, input logic [4:0] l);
    @(posedge clk); #1;
    t_start    = cyc;
    start      = 1'b1;
    first_addr = f;
    last_addr  = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Expected words are a snapshot of the bench register file at request time.
  task automatic start_dump(input int f, input int l);
    word_t w;
    for (int a = f; a <= l; a++) begin
      w.addr = 5'(a);
      w.data = regs[a];
      exp_q.push_back(w);
    end
    raw_start(5'(f), 5'(l));
    in_dump = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) @(posedge clk);
    #1;
    chk("done_timeout", (done_cnt > d0), 1);
  endtask

  int d_before, e_before, a_before;

  initial begin
    rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;

    // Full dump with ready held high
    out_ready = 1'b1;
    start_dump(0, 31);
    wait_done(200);
    chk("full_done_timing", done_cyc, t_start + 65);
    for (int i = 0; i < 32; i++) chk("full_word_spacing", word_cyc[i], t_start + 2 + 2 * i);
    chk("full_lit_addr0", got_data[0], 32'h1000_0000);
    chk("full_lit_addr31", got_data[31], 32'h1000_001F);
    chk("full_done_count", done_cnt, 1);

    // Rejected range
    e_before = err_cnt;
    raw_start(5'd5, 5'd3);
    @(negedge clk);
    chk("err_pulse_high", err, 1);
    chk("err_busy_low", busy, 0);
    @(negedge clk);
    chk("err_pulse_one_cycle", err, 0);
    repeat (4) begin
      @(negedge clk);
      chk("err_no_valid", out_valid, 0);
      chk("err_busy_stays_low", busy, 0);
    end
    chk("err_count", err_cnt, e_before + 1);

    // Single word at the top address
    regs[31] = 32'hDEAD_BEEF;
    a_before = accepted;
    start_dump(31, 31);
    wait_done(50);
    chk("top_one_word", accepted, a_before + 1);
    chk("top_lit_data", got_data[31], 32'hDEAD_BEEF);
    chk("top_first_valid", word_cyc[31], t_start + 2);
    chk("top_done_timing", done_cyc, t_start + 3);
    repeat (3) @(negedge clk);
    chk("top_no_wrap", out_valid, 0);

    // Back-pressure on the word at address 3
    start_dump(2, 4);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk); #1;
        if (out_valid && out_addr == 5'd3) seen = 1'b1;
      end
      chk("stall_word3_seen", seen, 1);
    end
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_addr_held", out_addr, 5'd3);
    chk("stall_data_held", out_data, 32'h1000_0003);
    chk("stall_valid_held", out_valid, 1);
    out_ready = 1'b1;
    wait_done(50);
    chk("stall_lit_addr4", got_data[4], 32'h1000_0004);

    // Snapshot semantics: register 6 written before its read, register 1 after its read
    regs[6] = 32'hCAFE_0006;
    a_before = accepted;
    start_dump(0, 7);
    for (int i = 0; i < 40 && accepted < a_before + 2; i++) @(posedge clk);
    chk("snap_reached_word2", (accepted >= a_before + 2), 1);
    regs[1] = 32'h0000_0BAD;
    wait_done(60);
    chk("snap_lit_addr6", got_data[6], 32'hCAFE_0006);
    chk("snap_lit_addr1", got_data[1], 32'h1000_0001);

    // Asynchronous reset in the middle of a dump
    d_before = done_cnt;
    a_before = accepted;
    start_dump(0, 31);
    for (int i = 0; i < 60 && !(accepted >= a_before + 10 && out_valid); i++) begin
      @(posedge clk); #1;
    end
    chk("mid_reached_send", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    in_dump = 1'b0;
    fresh   = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_no_done_pulse", done_cnt, d_before);

    // Fresh dump after reset, with start pulses that must be ignored while busy
    for (int i = 0; i < 32; i++) regs[i] = 32'h2000_0000 + 32'(i * 3);
    d_before = done_cnt;
    e_before = err_cnt;
    a_before = accepted;
    start_dump(0, 31);
    repeat (3) @(posedge clk);
    raw_start(5'd5, 5'd3);
    repeat (4) @(posedge clk);
    raw_start(5'd0, 5'd1);
    wait_done(200);
    chk("redo_word_count", accepted, a_before + 32);
    chk("redo_done_count", done_cnt, d_before + 1);
    chk("redo_no_err", err_cnt, e_before);
    chk("redo_lit_addr10", got_data[10], 32'h2000_001E);
    repeat (4) @(negedge clk);
    chk("redo_idle_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
Name: regfile_dump_reader

Overview:
- Debug/verification-side reader for the 32x32 register file's combinational read port.
- On a start command it walks a contiguous register address range and drives each address onto the file's read address.
- Each returned word is captured and streamed out, tagged with its address, over a valid/ready handshake.
- Sits beside the datapath; used by test benches and the debug link to snapshot architectural state.

Parameters:
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a dump; sampled in IDLE only.
- first_addr  in  ADDR_W  first register of the range; sampled with start.
- last_addr  in  ADDR_W  last register of the range, inclusive; sampled with start.
- rf_addr  out  ADDR_W  read address driven to the register file read port.
- rf_data  in  DATA_W  combinational read data from the register file for rf_addr.
- out_valid  out  1  out_addr/out_data hold a valid word.
- out_ready  in  1  consumer accepts the word.
- out_addr  out  ADDR_W  register index of the current word.
- out_data  out  DATA_W  register contents of the current word.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last word is accepted.
- err  out  1  one-cycle pulse when start is rejected (first_addr > last_addr).

Behaviour:
- Reset (async, rst=1): state=IDLE; cur, last_q, rf_addr, out_addr, out_data = 0; out_valid, busy, done, err = 0. Reset mid-dump aborts immediately; no done pulse.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - rf_addr=0.
  - start=1 and first_addr<=last_addr: cur<=first_addr, last_q<=last_addr, busy<=1, go READ.
  - start=1 and first_addr>last_addr: err<=1 for one cycle, stay IDLE, busy stays 0.
- READ (one cycle):
  - rf_addr=cur, combinationally.
  - At the clock edge: out_data<=rf_data, out_addr<=cur, out_valid<=1, go SEND.
- SEND:
  - out_valid=1; out_addr and out_data stable until the handshake.
  - out_valid=1 and out_ready=1 at the edge is the handshake: out_valid<=0.
  - On handshake, if cur==last_q go DONE; otherwise cur<=cur+1, go READ.
  - cur==last_q is compared before any increment, so last_addr=31 never wraps. Range 31..31 yields exactly one word.
- DONE (one cycle): done=1, busy<=0, go IDLE. busy is low in the same cycle done is high.
- start while not in IDLE is ignored; no err pulse.
- Latency and throughput:
  - start at edge N gives out_valid=1 after edge N+2.
  - With out_ready held high, one word every 2 cycles.
  - A range of k words finishes with the done pulse 2k+1 cycles after the start edge.
- Snapshot semantics: each word is the register value at the end of its READ cycle. A write to a register before its READ edge is visible in the dump; a write after it is not.
- x0 is read like any other address; the block does not special-case it.
- out_ready asserted while out_valid=0 has no effect.

Test Plan:
- Preload regs[i]=0x1000_0000+i; start with first=0, last=31, out_ready=1 -> 32 words, out_addr 0..31 in order, out_data=0x1000_0000+i, spaced 2 cycles apart; single done pulse; busy high across the whole dump.
- start with first=5, last=3 -> err=1 for one cycle, out_valid never rises, busy stays 0, state IDLE.
- first=31, last=31, regs[31]=0xDEADBEEF -> exactly one word {31, 0xDEADBEEF}, then done; cur never wraps to 0.
- first=2, last=4, out_ready low for 5 cycles on the word at addr 3 -> out_addr=3 and out_data held stable while stalled; word 4 follows after ready rises; ordering preserved.
- During a 0..7 dump, write regs[6]=0xCAFE0006 before READ(6) and regs[1]=0xBAD after READ(1) -> dump shows 0xCAFE0006 for addr 6 and the old value for addr 1.
- Assert rst mid-SEND of a 0..31 dump -> out_valid, busy and done drop to 0 asynchronously; a new start after reset runs a full dump correctly; start pulses issued while busy are ignored.
